commit_rat: RTL and testbench

COMMIT_RAT -- requirements
Module: commit_rat

---
 rtl/commit_rat.sv | 133 +++++++++++++
 tb/tb_commit_rat.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_rat.sv
// Commit-stage rename alias table with a release queue that feeds displaced PRFs back to the free list.
// Optional debug read port of the committed map: define COMMIT_RAT_QUERY_EN.

`ifndef RENAME_WIDTH
`define RENAME_WIDTH 2
`endif
`ifndef ARF_INT_SIZE
`define ARF_INT_SIZE 32
`endif
`ifndef ARF_INT_INDEX_SIZE
`define ARF_INT_INDEX_SIZE 5
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 6
`endif

module commit_rat (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic [`RENAME_WIDTH-1:0]                              commit_valid,
    input  logic [`RENAME_WIDTH-1:0][`ARF_INT_INDEX_SIZE-1:0]     commit_rd,
    input  logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]     commit_prd,
    input  logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]     commit_prev_rd,
    input  logic [`RENAME_WIDTH-1:0]                              commit_prev_rd_valid,
    output logic                                                  commit_ready,
    input  logic                                                  release_stall,
    output logic [`RENAME_WIDTH-1:0]                              replace_req,
    output logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]     replace_prf,
    output logic [`ARF_INT_SIZE-1:0][`PRF_INT_INDEX_SIZE-1:0]     arch_map
`ifdef COMMIT_RAT_QUERY_EN
    ,
    input  logic [`ARF_INT_INDEX_SIZE-1:0]                        query_rd,
    output logic [`PRF_INT_INDEX_SIZE-1:0]                        query_prd
`endif
);

    localparam int unsigned RW     = `RENAME_WIDTH;
    localparam int unsigned QDEPTH = 2 * RW;
    localparam int unsigned PRF_W  = `PRF_INT_INDEX_SIZE;
    localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);

    logic [QDEPTH-1:0][PRF_W-1:0]                             queue_q;
    logic [PTR_W-1:0]                                         head_q;
    logic [PTR_W-1:0]                                         tail_q;
    logic [CNT_W-1:0]                                         occ_q;

    logic [`ARF_INT_SIZE-1:0][PRF_W-1:0]                      map_next;
    logic [QDEPTH-1:0]                                        q_wr_en;
    logic [QDEPTH-1:0][PRF_W-1:0]                             q_wr_data;
    logic [PTR_W-1:0]                                         wr_ptr;
    logic [CNT_W-1:0]                                         push_cnt;
    logic [CNT_W-1:0]                                         pop_cnt;
    logic [RW-1:0]                                            rep_req_next;
    logic [RW-1:0][PRF_W-1:0]                                 rep_prf_next;

    // Pointer advance modulo QDEPTH (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = (32'(p) + k) % QDEPTH;
        return PTR_W'(s);
    endfunction

    // Room for a whole group, from registered occupancy only.
    assign commit_ready = (QDEPTH - 32'(occ_q)) >= RW;

    // Map update (younger lane wins) and compacted push of displaced PRFs.
    always_comb begin
        map_next  = arch_map;
        q_wr_en   = '0;
        q_wr_data = '0;
        push_cnt  = '0;
        wr_ptr    = tail_q;
        for (int unsigned i = 0; i < RW; i++) begin
            if (commit_valid[i] && commit_ready) begin
                if (commit_rd[i] != '0) begin
                    map_next[commit_rd[i]] = commit_prd[i];
                end
                if (commit_prev_rd_valid[i]) begin
                    q_wr_en[wr_ptr]   = 1'b1;
                    q_wr_data[wr_ptr] = commit_prev_rd[i];
                    wr_ptr            = ptr_add(wr_ptr, 1);
                    push_cnt          = push_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Pop from pre-push contents; pushes only land in free slots, so no overlap.
    always_comb begin
        pop_cnt      = '0;
        rep_req_next = '0;
        rep_prf_next = '0;
        if (!release_stall) begin
            pop_cnt = (32'(occ_q) < RW) ? occ_q : CNT_W'(RW);
        end
        for (int unsigned i = 0; i < RW; i++) begin
            if (i < 32'(pop_cnt)) begin
                rep_req_next[i] = 1'b1;
                rep_prf_next[i] = queue_q[ptr_add(head_q, i)];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arch_map    <= '0;
            queue_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            replace_req <= '0;
            replace_prf <= '0;
        end else begin
            arch_map    <= map_next;
            head_q      <= ptr_add(head_q, 32'(pop_cnt));
            tail_q      <= wr_ptr;
            occ_q       <= occ_q + push_cnt - pop_cnt;
            replace_req <= rep_req_next;
            replace_prf <= rep_prf_next;
            for (int unsigned j = 0; j < QDEPTH; j++) begin
                if (q_wr_en[j]) begin
                    queue_q[j] <= q_wr_data[j];
                end
            end
        end
    end

`ifdef COMMIT_RAT_QUERY_EN
    assign query_prd = arch_map[query_rd];
`endif

endmodule

// File: tb/tb_commit_rat.sv
// Directed bench for commit_rat: map updates, release ordering, stall back-pressure, wrap-around and async reset.

`ifndef RENAME_WIDTH
`define RENAME_WIDTH 2
`endif
`ifndef ARF_INT_SIZE
`define ARF_INT_SIZE 32
`endif
`ifndef ARF_INT_INDEX_SIZE
`define ARF_INT_INDEX_SIZE 5
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 6
`endif

module tb_commit_rat;

    localparam int unsigned RW    = `RENAME_WIDTH;
    localparam int unsigned ARF_W = `ARF_INT_INDEX_SIZE;
    localparam int unsigned PRF_W = `PRF_INT_INDEX_SIZE;

    logic                                   clock;
    logic                                   reset;
    logic [RW-1:0]                          commit_valid;
    logic [RW-1:0][ARF_W-1:0]               commit_rd;
    logic [RW-1:0][PRF_W-1:0]               commit_prd;
    logic [RW-1:0][PRF_W-1:0]               commit_prev_rd;
    logic [RW-1:0]                          commit_prev_rd_valid;
    logic                                   commit_ready;
    logic                                   release_stall;
    logic [RW-1:0]                          replace_req;
    logic [RW-1:0][PRF_W-1:0]               replace_prf;
    logic [`ARF_INT_SIZE-1:0][PRF_W-1:0]    arch_map;
`ifdef COMMIT_RAT_QUERY_EN
    logic [ARF_W-1:0]                       query_rd;
    logic [PRF_W-1:0]                       query_prd;
`endif

    int compared   = 0;
    int mismatched = 0;

    commit_rat dut (
        .clock                (clock),
        .reset                (reset),
        .commit_valid         (commit_valid),
        .commit_rd            (commit_rd),
        .commit_prd           (commit_prd),
        .commit_prev_rd       (commit_prev_rd),
        .commit_prev_rd_valid (commit_prev_rd_valid),
        .commit_ready         (commit_ready),
        .release_stall        (release_stall),
        .replace_req          (replace_req),
        .replace_prf          (replace_prf),
        .arch_map             (arch_map)
`ifdef COMMIT_RAT_QUERY_EN
        ,
        .query_rd             (query_rd),
        .query_prd            (query_prd)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int l, input logic v, input int rd, input int prd,
                            input int prev, input logic pv);
        commit_valid[l]         = v;
        commit_rd[l]            = ARF_W'(rd);
        commit_prd[l]           = PRF_W'(prd);
        commit_prev_rd[l]       = PRF_W'(prev);
        commit_prev_rd_valid[l] = pv;
    endtask

    task automatic clear_lanes();
        commit_valid         = '0;
        commit_rd            = '0;
        commit_prd           = '0;
        commit_prev_rd       = '0;
        commit_prev_rd_valid = '0;
    endtask

    initial begin
        clock         = 1'b0;
        reset         = 1'b1;
        release_stall = 1'b0;
        clear_lanes();
`ifdef COMMIT_RAT_QUERY_EN
        query_rd = '0;
`endif

        // Reset state
        #1;
        check("rst_ready", 32'(commit_ready), 1);
        check("rst_req", 32'(replace_req), 0);
        check("rst_prf", 32'(replace_prf != '0), 0);
        check("rst_map", 32'(arch_map != '0), 0);
        step();
        step();
        reset = 1'b0;
        check("post_rst_ready", 32'(commit_ready), 1);

        // Single commit: map visible next cycle, release one cycle after that
        set_lane(0, 1'b1, 5, 40, 5, 1'b1);
        step();
        clear_lanes();
        check("a_map5", 32'(arch_map[5]), 40);
        check("a_req_early", 32'(replace_req), 0);
        step();
        check("a_req", 32'(replace_req), 1);
        check("a_prf0", 32'(replace_prf[0]), 5);
`ifdef COMMIT_RAT_QUERY_EN
        query_rd = ARF_W'(5);
        #1;
        check("a_query", 32'(query_prd), 40);
`endif
        step();
        check("a_req_done", 32'(replace_req), 0);

        // Same rd on both lanes: younger lane wins, releases in lane order
        set_lane(0, 1'b1, 7, 33, 10, 1'b1);
        set_lane(1, 1'b1, 7, 34, 11, 1'b1);
        step();
        clear_lanes();
        check("b_map7", 32'(arch_map[7]), 34);
        check("b_map5_kept", 32'(arch_map[5]), 40);
        step();
        check("b_req", 32'(replace_req), 3);
        check("b_prf0", 32'(replace_prf[0]), 10);
        check("b_prf1", 32'(replace_prf[1]), 11);

        // rd = 0 never maps, but its prev is still released
        set_lane(0, 1'b1, 0, 12, 20, 1'b1);
        step();
        clear_lanes();
        check("c_map0", 32'(arch_map[0]), 0);
        step();
        check("c_req", 32'(replace_req), 1);
        check("c_prf0", 32'(replace_prf[0]), 20);

        // Only lane 1 releases: compacts into replace lane 0
        set_lane(0, 1'b1, 3, 21, 0, 1'b0);
        set_lane(1, 1'b1, 4, 22, 23, 1'b1);
        step();
        clear_lanes();
        check("d_map3", 32'(arch_map[3]), 21);
        check("d_map4", 32'(arch_map[4]), 22);
        step();
        check("d_req", 32'(replace_req), 1);
        check("d_prf0", 32'(replace_prf[0]), 23);

        // Stall back-pressure: fill queue, ignored group, then FIFO drain
        release_stall = 1'b1;
        set_lane(0, 1'b1, 8, 50, 1, 1'b1);
        set_lane(1, 1'b1, 9, 51, 2, 1'b1);
        check("e_ready0", 32'(commit_ready), 1);
        step();
        check("e_ready1", 32'(commit_ready), 1);
        check("e_req1", 32'(replace_req), 0);
        set_lane(0, 1'b1, 10, 52, 3, 1'b1);
        set_lane(1, 1'b1, 11, 53, 4, 1'b1);
        step();
        check("e_ready2", 32'(commit_ready), 0);
        check("e_req2", 32'(replace_req), 0);
        check("e_map10", 32'(arch_map[10]), 52);
        set_lane(0, 1'b1, 8, 60, 5, 1'b1);
        set_lane(1, 1'b1, 9, 61, 6, 1'b1);
        step();
        check("e_map8_ignored", 32'(arch_map[8]), 50);
        check("e_ready3", 32'(commit_ready), 0);
        check("e_req3", 32'(replace_req), 0);
        clear_lanes();
        release_stall = 1'b0;
        step();
        check("e_drain1_req", 32'(replace_req), 3);
        check("e_drain1_prf0", 32'(replace_prf[0]), 1);
        check("e_drain1_prf1", 32'(replace_prf[1]), 2);
        check("e_drain1_ready", 32'(commit_ready), 1);
        step();
        check("e_drain2_req", 32'(replace_req), 3);
        check("e_drain2_prf0", 32'(replace_prf[0]), 3);
        check("e_drain2_prf1", 32'(replace_prf[1]), 4);
        step();
        check("e_drain3_req", 32'(replace_req), 0);

        // Continuous push/pop across several pointer wraps
        for (int k = 0; k < 6; k++) begin
            set_lane(0, 1'b1, 13, 2 * k, 30 + 2 * k, 1'b1);
            set_lane(1, 1'b1, 14, 2 * k + 1, 31 + 2 * k, 1'b1);
            step();
            check("f_ready", 32'(commit_ready), 1);
            if (k == 0) begin
                check("f_req_first", 32'(replace_req), 0);
            end else begin
                check("f_req", 32'(replace_req), 3);
                check("f_prf0", 32'(replace_prf[0]), 32'(30 + 2 * (k - 1)));
                check("f_prf1", 32'(replace_prf[1]), 32'(31 + 2 * (k - 1)));
            end
        end
        clear_lanes();
        check("f_map14", 32'(arch_map[14]), 11);
        step();
        check("f_last_req", 32'(replace_req), 3);
        check("f_last_prf0", 32'(replace_prf[0]), 40);
        check("f_last_prf1", 32'(replace_prf[1]), 41);
        step();
        check("f_empty_req", 32'(replace_req), 0);

        // Async reset with three queued releases discards them
        release_stall = 1'b1;
        set_lane(0, 1'b1, 12, 44, 41, 1'b1);
        set_lane(1, 1'b1, 15, 45, 42, 1'b1);
        step();
        set_lane(0, 1'b1, 16, 46, 43, 1'b1);
        set_lane(1, 1'b0, 0, 0, 0, 1'b0);
        step();
        clear_lanes();
        check("g_ready_full", 32'(commit_ready), 0);
        check("g_map12", 32'(arch_map[12]), 44);
        #2;
        reset = 1'b1;
        #1;
        check("g_async_map", 32'(arch_map != '0), 0);
        check("g_async_req", 32'(replace_req), 0);
        check("g_async_ready", 32'(commit_ready), 1);
        step();
        reset = 1'b0;
        release_stall = 1'b0;
        step();
        check("g_discard_req1", 32'(replace_req), 0);
        check("g_post_ready", 32'(commit_ready), 1);
        step();
        check("g_discard_req2", 32'(replace_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
